// File: rtl/step_pkg.sv
// Shared definitions for the step issuer: default widths and FSM state encoding.
package step_pkg;

    localparam int MAX_W_DEF  = 12;
    localparam int PASS_W_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } step_state_t;

endpackage

// File: rtl/step_shadow_chk.sv
// Shadow copy of the downstream step counter; flags any ov that disagrees with it.
// The flag is sticky until the next command accept (clear).
module step_shadow_chk
    import step_pkg::*;
#(
    parameter int MAX_W = MAX_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             cnt,
    input  logic             ov,
    input  logic [MAX_W-1:0] max,
    output logic             err
);

    logic [MAX_W-1:0] shadow_q;
    logic             at_end;

    assign at_end = (shadow_q == (max - MAX_W'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q <= '0;
            err      <= 1'b0;
        end else if (clear) begin
            shadow_q <= '0;
            err      <= 1'b0;
        end else if (cnt) begin
            shadow_q <= at_end ? '0 : shadow_q + MAX_W'(1);
            if (ov != at_end) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_issuer.sv
// Issues paced step strobes to a step_counter for (steps per pass) x (passes) commands.
// Define STEP_SHADOW_CHECK_EN to add the shadow-counter consistency check on err.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// LOAD     | new max presented to the counter, no step yet
// RUN      | steps follow step_ready one cycle later
// DRAIN    | aborted; stepping unconditionally until the counter wraps
// DONE     | one-cycle done pulse, then back to IDLE
module step_issuer
    import step_pkg::*;
#(
    parameter int MAX_W  = MAX_W_DEF,
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [MAX_W-1:0]  cmd_max,
    input  logic [PASS_W-1:0] cmd_passes,
    input  logic              abort,
    input  logic              step_ready,
    output logic              cnt,
    output logic [MAX_W-1:0]  max,
    input  logic              ov,
    output logic              pass_done,
    output logic              done,
    output logic              busy,
    output logic              err
);

    step_state_t       state_q, state_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic [MAX_W-1:0]  max_d;
    logic              cnt_d, pass_done_d, ready_d, busy_d, done_d;
    logic              accept, ov_hit;

    assign accept = cmd_valid & cmd_ready;
    assign ov_hit = cnt & ov;

    always_comb begin
        state_d     = state_q;
        passes_d    = passes_q;
        max_d       = max;
        cnt_d       = 1'b0;
        pass_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    max_d    = cmd_max;
                    passes_d = cmd_passes;
                    state_d  = (cmd_max == '0 || cmd_passes == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = step_ready;
                end
            end
            ST_RUN: begin
                if (ov_hit) begin
                    passes_d    = passes_q - PASS_W'(1);
                    pass_done_d = 1'b1;
                end
                // A pass that ends in the abort cycle already left the counter at 0.
                if (ov_hit && (passes_q == PASS_W'(1) || abort)) begin
                    state_d = ST_DONE;
                end else if (abort) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 1'b1;
                end else begin
                    cnt_d = step_ready;
                end
            end
            ST_DRAIN: begin
                if (ov_hit) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            passes_q  <= '0;
            max       <= '0;
            cnt       <= 1'b0;
            pass_done <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            passes_q  <= passes_d;
            max       <= max_d;
            cnt       <= cnt_d;
            pass_done <= pass_done_d;
            cmd_ready <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef STEP_SHADOW_CHECK_EN
    step_shadow_chk #(.MAX_W(MAX_W)) u_shadow (
        .clk   (clk),
        .rstn  (rstn),
        .clear (accept),
        .cnt   (cnt),
        .ov    (ov),
        .max   (max),
        .err   (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_step_issuer.sv
// Bench for step_issuer paired with a behavioural step_counter.
module tb_step_issuer;
    import step_pkg::*;

    localparam int MW = 12;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [MW-1:0] cmd_max = '0;
    logic [PW-1:0] cmd_passes = '0;
    logic          abort = 1'b0;
    logic          step_ready = 1'b0;
    logic          ov_force = 1'b0;
    logic          cmd_ready, cnt, pass_done, done, busy, err, ov;
    logic [MW-1:0] max;
    logic [MW-1:0] ctr;

    step_issuer #(.MAX_W(MW), .PASS_W(PW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_max    (cmd_max),
        .cmd_passes (cmd_passes),
        .abort      (abort),
        .step_ready (step_ready),
        .cnt        (cnt),
        .max        (max),
        .ov         (ov),
        .pass_done  (pass_done),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // downstream step counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ctr <= '0;
        else if (cnt) ctr <= (ctr == max - MW'(1)) ? '0 : ctr + MW'(1);
    end
    assign ov = (cnt & (ctr == max - MW'(1))) | ov_force;

    int n_checks = 0;
    int n_fail   = 0;
    int r_cnt, r_pd, r_done, r_last_cnt, r_done_k, r_first_ov, r_viol, r_timeout;

    typedef struct {
        int m; int p; int mode; int abort_at;
        int exp_cnt; int exp_pd; int exp_done_k; int exp_first_ov;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mode 0: step_ready always 1, 1: toggling 1,0,1,..., 2: random with density dens%
    task automatic run_cmd(input int m, input int p, input int mode, input int abort_at, input int dens);
        int n;
        bit prev_sr, drained, exp_pd;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        check("cmd_ready_before_accept", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_max = MW'(m); cmd_passes = PW'(p);
        step_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        r_pd = 0; r_done = 0; r_last_cnt = 0; r_done_k = 0;
        r_first_ov = -1; r_viol = 0; r_timeout = 1;
        n = 0; prev_sr = 0; drained = 0; exp_pd = 0;
        for (int k = 1; k <= 6000; k++) begin
            if (cnt) begin
                n++;
                if (!drained && !prev_sr) r_viol++;
                r_last_cnt = k;
                if (ov && r_first_ov < 0) r_first_ov = n;
            end
            if (pass_done !== exp_pd) r_viol++;
            if (pass_done) r_pd++;
            if (busy !== !done) r_viol++;
            if (cmd_ready) r_viol++;
            if (max !== MW'(m)) r_viol++;
            exp_pd = cnt && !drained && m > 0 && (n % m == 0);
            if (done) begin
                r_done++; r_done_k = k; r_timeout = 0;
                break;
            end
            abort = 1'b0;
            if (abort_at > 0 && !drained && n == abort_at) begin
                abort = 1'b1; drained = 1;
            end
            case (mode)
                0:       step_ready = 1'b1;
                1:       step_ready = (k % 2 == 1);
                default: step_ready = ($urandom_range(99) < dens);
            endcase
            prev_sr = step_ready;
            @(negedge clk);
        end
        r_cnt = n;
        abort = 1'b0; step_ready = 1'b0;
    endtask

    task automatic verify(input string nm, input int exp_cnt, input int exp_pd,
                          input int exp_done_k, input int exp_first_ov);
        int want_k;
        want_k = (exp_done_k > 0) ? exp_done_k : r_last_cnt + 1;
        check({nm, "_timeout"}, r_timeout, 0);
        check({nm, "_cnt_total"}, r_cnt, exp_cnt);
        check({nm, "_pass_done_total"}, r_pd, exp_pd);
        check({nm, "_done_total"}, r_done, 1);
        check({nm, "_done_cycle"}, r_done_k, want_k);
        check({nm, "_first_ov_step"}, r_first_ov, exp_first_ov);
        check({nm, "_protocol_viol"}, r_viol, 0);
        check({nm, "_counter_home"}, 32'(ctr), 0);
        check({nm, "_err"}, 32'(err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, p, a, tot, pd;
        tbl[0] = '{13, 2,    0, 0,  26,   2,    28,   13};
        tbl[1] = '{4,  1,    1, 0,  4,    1,    9,    4};
        tbl[2] = '{60, 3,    0, 70, 120,  1,    122,  60};
        tbl[3] = '{5,  1,    0, 0,  5,    1,    7,    5};
        tbl[4] = '{0,  7,    0, 0,  0,    0,    1,    -1};
        tbl[5] = '{9,  0,    0, 0,  0,    0,    1,    -1};
        tbl[6] = '{1,  5,    0, 0,  5,    5,    7,    1};
        tbl[7] = '{1,  4095, 0, 0,  4095, 4095, 4097, 1};

        #12;
        check("reset_flags", 32'({cmd_ready, cnt, pass_done, done, busy, err}), 0);
        check("reset_max", 32'(max), 0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].m, tbl[i].p, tbl[i].mode, tbl[i].abort_at, 100);
            verify($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_pd,
                   tbl[i].exp_done_k, tbl[i].exp_first_ov);
        end

        // abort while in LOAD: straight to done, no steps
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1; cmd_max = 12'd5; cmd_passes = 12'd2;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b1; step_ready = 1'b1;
        @(negedge clk);
        check("load_abort_done", 32'(done), 1);
        check("load_abort_no_cnt", 32'(cnt), 0);
        abort = 1'b0; step_ready = 1'b0;
        @(negedge clk);
        check("load_abort_counter_home", 32'(ctr), 0);

        // asynchronous reset in the middle of a pass
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1; cmd_max = 12'd13; cmd_passes = 12'd1;
        @(negedge clk);
        cmd_valid = 1'b0; step_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 6; i++) begin
            @(negedge clk);
            if (cnt) n++;
        end
        check("midrun_steps_seen", n, 6);
        #2 rstn = 1'b0;
        #1;
        check("midrun_reset_flags", 32'({cmd_ready, cnt, pass_done, done, busy, err}), 0);
        check("midrun_reset_max", 32'(max), 0);
        step_ready = 1'b0;
        @(negedge clk); rstn = 1'b1;
        run_cmd(13, 1, 0, 0, 100);
        verify("after_reset", 13, 1, 15, 13);

        // randomized commands against the pass/step arithmetic
        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(9, 1);
            p = $urandom_range(3, 0);
            if ($urandom_range(9) == 0) m = 0;
            a = 0;
            if (m > 1 && p > 0 && $urandom_range(2) == 0) begin
                a = $urandom_range(m * p - 1, 1);
                if (a % m == 0) a = 0;
            end
            if (m == 0 || p == 0) begin
                tot = 0; pd = 0;
            end else if (a > 0) begin
                tot = ((a + m - 1) / m) * m; pd = a / m;
            end else begin
                tot = m * p; pd = p;
            end
            run_cmd(m, p, 2, a, $urandom_range(100, 20));
            verify($sformatf("rand%0d_m%0d_p%0d_a%0d", it, m, p, a), tot, pd,
                   (tot == 0) ? 1 : -1, (tot == 0) ? -1 : m);
        end

`ifdef STEP_SHADOW_CHECK_EN
        // spurious ov at step 5 of a 13-step pass
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1; cmd_max = 12'd13; cmd_passes = 12'd1;
        @(negedge clk);
        cmd_valid = 1'b0; step_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 5; i++) begin
            @(negedge clk);
            if (cnt) n++;
        end
        check("shadow_steps_seen", n, 5);
        check("shadow_err_before", 32'(err), 0);
        ov_force = 1'b1;
        @(negedge clk);
        ov_force = 1'b0; step_ready = 1'b0;
        check("shadow_err_set", 32'(err), 1);
        repeat (3) @(negedge clk);
        check("shadow_err_sticky", 32'(err), 1);
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1; cmd_max = 12'd13; cmd_passes = 12'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("shadow_err_cleared", 32'(err), 0);
        rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
